tap_controller: RTL

- IEEE 1149.1-style TAP controller and instruction register that sequences the boundary-scan datapath.
- Runs the 16-state TAP FSM from TMS and owns the 3-bit instruction register (IR).
- Drives Instruction, ShiftDR, UpdateDR and ClockDR into the instruction decoder, which gates them onto the bypass and boundary-scan registers.
- Also drives the TDO source select and the TDO enable.

---
 rtl/tap_pkg.sv | 78 +++++++
 rtl/tap_ir_register.sv | 45 ++++
 rtl/tap_controller.sv | 72 +++++++
 3 files changed

// File: rtl/tap_pkg.sv
// Purpose: shared TAP definitions: state codes, IR length, opcodes, state helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; the TAP port has no flow control, TCK paces everything.
package tap_pkg;

   localparam int IR_WIDTH = 3;

   // Instruction opcodes, shared with the instruction decoder.
   localparam logic [IR_WIDTH-1:0] OP_BYPASS  = 3'b111;
   localparam logic [IR_WIDTH-1:0] OP_INTEST  = 3'b011;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = 3'b010;
   localparam logic [IR_WIDTH-1:0] OP_PRELOAD = 3'b001;
   localparam logic [IR_WIDTH-1:0] OP_EXTEST  = 3'b000;

   // Standard 1149.1 state encoding; all 16 codes are legal states.
   typedef enum logic [3:0] {
      EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUDR = 4'h3,
      SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
      EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUIR = 4'hB,
      RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
   } tap_state_e;

   // Per-state control strobes.
   typedef struct packed {
      logic shift_dr;
      logic update_dr;
      logic clock_dr;
      logic shift_ir;
      logic select_ir;
      logic tdo_enable;
      logic cap_ir;
      logic upd_ir;
      logic tlr;
   } tap_ctl_t;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TLR:     n = tms ? TLR   : RTI;
         RTI:     n = tms ? SELDR : RTI;
         SELDR:   n = tms ? SELIR : CAPDR;
         CAPDR:   n = tms ? EX1DR : SHDR;
         SHDR:    n = tms ? EX1DR : SHDR;
         EX1DR:   n = tms ? UPDDR : PAUDR;
         PAUDR:   n = tms ? EX2DR : PAUDR;
         EX2DR:   n = tms ? UPDDR : SHDR;
         UPDDR:   n = tms ? SELDR : RTI;
         SELIR:   n = tms ? TLR   : CAPIR;
         CAPIR:   n = tms ? EX1IR : SHIR;
         SHIR:    n = tms ? EX1IR : SHIR;
         EX1IR:   n = tms ? UPDIR : PAUIR;
         PAUIR:   n = tms ? EX2IR : PAUIR;
         EX2IR:   n = tms ? UPDIR : SHIR;
         UPDIR:   n = tms ? SELDR : RTI;
         // Only reachable with an unknown state in simulation: fall back to TLR.
         default: n = TLR;
      endcase
      return n;
   endfunction

   function automatic tap_ctl_t tap_decode(input tap_state_e s);
      tap_ctl_t c;
      c            = '0;
      c.shift_dr   = (s == SHDR);
      c.update_dr  = (s == UPDDR);
      c.clock_dr   = (s == CAPDR) || (s == SHDR);
      c.shift_ir   = (s == SHIR);
      c.tdo_enable = (s == SHDR) || (s == SHIR);
      c.cap_ir     = (s == CAPIR);
      c.upd_ir     = (s == UPDIR);
      c.tlr        = (s == TLR);
      // IR column: SelIR through UpdIR.
      c.select_ir  = (s == SELIR) || (s == CAPIR) || (s == SHIR) || (s == EX1IR) ||
                     (s == PAUIR) || (s == EX2IR) || (s == UPDIR);
      return c;
   endfunction

endpackage

// File: rtl/tap_ir_register.sv
// Purpose: instruction register: capture/shift stage plus the updated (parallel) instruction.
// Latency: stage and Instruction change on the TCK edge that ends CapIR/ShIR/UpdIR/TLR.
// Backpressure: none; shifts one TDI bit per TCK while ShIR is high.
// Ports: TCK, Reset (sync, active high), TDI, CapIR/ShIR/UpdIR/InTlr state strobes in;
//        Instruction (current instruction), IrTdo (stage LSB) out.
module tap_ir_register #(
   parameter int                  IR_WIDTH   = tap_pkg::IR_WIDTH,
   parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] IR_RESET   = '1
) (
   input  logic                TCK,
   input  logic                Reset,
   input  logic                TDI,
   input  logic                CapIR,
   input  logic                ShIR,
   input  logic                UpdIR,
   input  logic                InTlr,
   output logic [IR_WIDTH-1:0] Instruction,
   output logic                IrTdo
);

   logic [IR_WIDTH-1:0] stage_q;
   logic [IR_WIDTH-1:0] instr_q;

   always_ff @(posedge TCK) begin
      if (Reset || InTlr) begin
         // Any partially shifted value is discarded here.
         stage_q <= IR_CAPTURE;
         instr_q <= IR_RESET;
      end else begin
         if (CapIR) begin
            stage_q <= IR_CAPTURE;
         end else if (ShIR) begin
            stage_q <= {TDI, stage_q[IR_WIDTH-1:1]};
         end
         if (UpdIR) begin
            instr_q <= stage_q;
         end
      end
   end

   assign Instruction = instr_q;
   assign IrTdo       = stage_q[0];

endmodule

// File: rtl/tap_controller.sv
// Purpose: 1149.1 TAP state machine, output strobe decode and instruction register.
// Latency: strobes are valid for exactly the TCK cycles spent in their state (one TCK after the TMS sample).
// Backpressure: none; TMS is consumed on every rising TCK edge.
// Ports: TCK, Reset, TMS, TDI in; Instruction, ShiftDR, UpdateDR, ClockDR, ShiftIR, IrTdo,
//        SelectIR, TdoEnable, TapState (debug copy of the state code) out.
module tap_controller #(
   parameter int                  IR_WIDTH   = tap_pkg::IR_WIDTH,
   parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] IR_RESET   = '1
) (
   input  logic                TCK,
   input  logic                Reset,
   input  logic                TMS,
   input  logic                TDI,
   output logic [IR_WIDTH-1:0] Instruction,
   output logic                ShiftDR,
   output logic                UpdateDR,
   output logic                ClockDR,
   output logic                ShiftIR,
   output logic                IrTdo,
   output logic                SelectIR,
   output logic                TdoEnable,
   output logic [3:0]          TapState
);

   import tap_pkg::*;

   tap_state_e state_q;
   tap_state_e state_d;
   tap_ctl_t   ctl_q;

   always_comb begin
      state_d = tap_next(state_q, TMS);
   end

   // Strobes are registered from the next state so they line up with state_q
   // without any combinational decode on the outputs.
   always_ff @(posedge TCK) begin
      if (Reset) begin
         state_q <= TLR;
         ctl_q   <= tap_decode(TLR);
      end else begin
         state_q <= state_d;
         ctl_q   <= tap_decode(state_d);
      end
   end

   tap_ir_register #(
      .IR_WIDTH   (IR_WIDTH),
      .IR_CAPTURE (IR_CAPTURE),
      .IR_RESET   (IR_RESET)
   ) u_ir (
      .TCK         (TCK),
      .Reset       (Reset),
      .TDI         (TDI),
      .CapIR       (ctl_q.cap_ir),
      .ShIR        (ctl_q.shift_ir),
      .UpdIR       (ctl_q.upd_ir),
      .InTlr       (ctl_q.tlr),
      .Instruction (Instruction),
      .IrTdo       (IrTdo)
   );

   assign ShiftDR   = ctl_q.shift_dr;
   assign UpdateDR  = ctl_q.update_dr;
   assign ClockDR   = ctl_q.clock_dr;
   assign ShiftIR   = ctl_q.shift_ir;
   assign SelectIR  = ctl_q.select_ir;
   assign TdoEnable = ctl_q.tdo_enable;
   assign TapState  = state_q;

endmodule
